// File: rtl/nibble_serial_adder_ctrl.sv
// Bit-serial (nibble-serial) add/subtract sequencer wrapped around an external
// combinational 4-bit adder stage; one nibble per cycle, LSB nibble first.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4,
    localparam int W  = 4 * NIBBLES,
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Valid must be held until the transfer. in_ready is high only in IDLE and
    // out_valid only in DONE, so an accept never coincides with a result hand-off.
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         overflow,
    output logic [3:0]   add_a,
    output logic [3:0]   add_b,
    output logic         add_cin,
    input  logic [3:0]   add_sum,
    input  logic         add_cout,
    input  logic         add_v,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          sub_q, sub_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic [IW+1:0] nib_base;

    assign nib_base = {idx_q, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = 4'h0;
        add_b     = 4'h0;
        add_cin   = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sub_d   = op_sub;
                    idx_d   = '0;
                    // Subtract is A + ~B + 1: the +1 enters as the first carry-in.
                    carry_d = op_sub;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                add_a   = a_q[nib_base +: 4];
                add_b   = b_q[nib_base +: 4] ^ {4{sub_q}};
                add_cin = carry_q;
                result_d[nib_base +: 4] = add_sum;
                carry_d = add_cout;
                if (idx_q == IW'(NIBBLES - 1)) begin
                    // Only the top nibble's v reflects signed overflow of the full word.
                    cout_d  = add_cout;
                    ovf_d   = add_v;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with a behavioural 4-bit adder
// closing the loop on the add_* pins.
module tb_nibble_serial_adder_ctrl;

    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;
    logic         add_v;
    logic [1:0]   dbg_state;

    int n_total;
    int n_bad;
    int lat;
    int n_log;
    logic       cin_log [0:7];
    logic [3:0] b_log   [0:7];
    logic [W+1:0] exp_q[$];

    nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .add_v     (add_v),
        .dbg_state (dbg_state)
    );

    // Golden 4-bit adder stage.
    logic [4:0] g_full;
    assign g_full   = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    assign add_sum  = g_full[3:0];
    assign add_cout = g_full[4];
    assign add_v    = (add_a[3] == add_b[3]) && (g_full[3] != add_a[3]);

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drivers
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); @(negedge clk);
            guard++;
        end
        if (!in_ready) check_val("issue_timeout", 32'(in_ready), 32'd1);
        op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        n_log = 0;
        while (!out_valid && lat < 20) begin
            if (n_log < 8) begin
                cin_log[n_log] = add_cin;
                b_log[n_log]   = add_b;
                n_log++;
            end
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check_val("latency", 32'(lat), 32'(NIBBLES));
    endtask

    task automatic finish_op(input string tag);
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check_val({tag, "_result"}, 32'(result), 32'(e[W-1:0]));
        check_val({tag, "_carry"}, 32'(carry_out), 32'(e[W+1]));
        check_val({tag, "_ovf"}, 32'(overflow), 32'(e[W]));
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check_val({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        check_val({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_sub = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_result", 32'(result), 32'd0);
        check_val("rst_add_pins", {26'd0, add_a, add_b[0], add_cin}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0x1234 + 0x0FCD: carries ripple through nibbles 0..2
        exp_q.push_back({1'b0, 1'b0, 16'h2201});
        issue(16'h1234, 16'h0FCD, 1'b0);
        check_val("cin_count", 32'(n_log), 32'd4);
        check_val("cin_seq", {28'd0, cin_log[0], cin_log[1], cin_log[2], cin_log[3]}, 32'h7);
        finish_op("add1");

        exp_q.push_back({1'b1, 1'b0, 16'h0000});
        issue(16'hFFFF, 16'h0001, 1'b0);
        finish_op("wrap");

        exp_q.push_back({1'b0, 1'b1, 16'h8000});
        issue(16'h7FFF, 16'h0001, 1'b0);
        finish_op("sovf");

        exp_q.push_back({1'b0, 1'b0, 16'hFFFE});
        issue(16'h0005, 16'h0007, 1'b1);
        check_val("sub_b0", 32'(b_log[0]), 32'h8);
        check_val("sub_cin0", 32'(cin_log[0]), 32'd1);
        finish_op("sub");

        // Back-pressure: hold the result while new operands are offered
        exp_q.push_back({1'b0, 1'b0, 16'h0123});
        issue(16'h0100, 16'h0023, 1'b0);
        for (int i = 0; i < 3; i++) begin
            op_a = 16'hAAAA; op_b = 16'h5555; op_sub = 1'b1; in_valid = 1'b1;
            @(posedge clk); @(negedge clk);
            check_val("bp_result", 32'(result), 32'h0123);
            check_val("bp_in_ready", 32'(in_ready), 32'd0);
            check_val("bp_out_valid", 32'(out_valid), 32'd1);
            check_val("bp_add_a", 32'(add_a), 32'd0);
        end
        in_valid = 1'b0;
        finish_op("bp");

        exp_q.push_back({1'b0, 1'b0, 16'h0005});
        issue(16'h0002, 16'h0003, 1'b0);
        finish_op("after_bp");

        // Asynchronous reset two cycles into RUN
        op_a = 16'h1234; op_b = 16'h0FCD; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_result", 32'(result), 32'd0);
        check_val("mid_rst_flags", {29'd0, out_valid, carry_out, overflow}, 32'd0);
        check_val("mid_rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
        check_val("mid_rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back({1'b0, 1'b0, 16'h0002});
        issue(16'h0001, 16'h0001, 1'b0);
        finish_op("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
